// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issue sequencer for the 8-bit ALU, owns result register and CCR {C,Z,N,V}
// Ports: clk/rst; issue port iss_valid/iss_ready/iss_op/iss_ra/iss_a/iss_b/iss_rd;
// registered ALU drive alu_a/alu_b/alu_op/alu_ra with result inputs alu_out/alu_c/z/n/v;
// writeback port wb_valid/wb_ready/wb_data/wb_rd/wb_err; flag register ccr.
// Optional build macro ALU_CCR_LOAD_EN adds ccr_ld/ccr_din for direct CCR restore.
module alu_issue_ctrl #(
  parameter int Width = 8
) (
  input  logic             clk,
  input  logic             rst,
`ifdef ALU_CCR_LOAD_EN
  input  logic             ccr_ld,
  input  logic [3:0]       ccr_din,
`endif
  input  logic             iss_valid,
  output logic             iss_ready,
  input  logic [3:0]       iss_op,
  input  logic [1:0]       iss_ra,
  input  logic [Width-1:0] iss_a,
  input  logic [Width-1:0] iss_b,
  input  logic [1:0]       iss_rd,
  output logic [Width-1:0] alu_a,
  output logic [Width-1:0] alu_b,
  output logic [3:0]       alu_op,
  output logic [1:0]       alu_ra,
  input  logic [Width-1:0] alu_out,
  input  logic             alu_c,
  input  logic             alu_z,
  input  logic             alu_n,
  input  logic             alu_v,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [Width-1:0] wb_data,
  output logic [1:0]       wb_rd,
  output logic             wb_err,
  output logic [3:0]       ccr
);
  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;
  state_t state, state_nxt;
  logic [1:0] rd_q;
  logic full, zn, nowb, legal;
  logic [3:0] ccr_nxt;
  assign iss_ready = state == IDLE;
  assign wb_valid  = state == WB;
  // full: all four flags from the ALU; zn: NOT/NEG keep C,V; nowb: CLRC/SETC set C from ra[0]
  always_comb begin
    full      = (alu_op inside {4'h2, 4'h3, 4'h4, 4'h5}) || (alu_op == 4'h6 && !alu_ra[1]) || (alu_op == 4'h8 && alu_ra[1]);
    zn        = alu_op == 4'h8 && !alu_ra[1];
    nowb      = alu_op == 4'h6 && alu_ra[1];
    legal     = full || zn || nowb;
    ccr_nxt   = state != EXEC ? ccr :
                full ? {alu_c, alu_z, alu_n, alu_v} :
                zn   ? {ccr[3], alu_z, alu_n, ccr[0]} :
                nowb ? {alu_ra[0], ccr[2:0]} : ccr;
`ifdef ALU_CCR_LOAD_EN
    ccr_nxt   = ccr_ld ? ccr_din : ccr_nxt;
`endif
    state_nxt = state == IDLE ? (iss_valid ? EXEC : IDLE) :
                state == EXEC ? (nowb ? IDLE : WB) :
                (wb_ready ? IDLE : WB);
  end
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_nxt;
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a   <= '0;
      alu_b   <= '0;
      alu_op  <= '0;
      alu_ra  <= '0;
      rd_q    <= '0;
      wb_data <= '0;
      wb_rd   <= '0;
      wb_err  <= 1'b0;
      ccr     <= '0;
    end else begin
      if (iss_valid && iss_ready) begin
        alu_a  <= iss_a;
        alu_b  <= iss_b;
        alu_op <= iss_op;
        alu_ra <= iss_ra;
        rd_q   <= iss_rd;
      end
      if (state == EXEC) begin
        wb_data <= legal ? alu_out : '0;
        wb_rd   <= rd_q;
        wb_err  <= !legal;
      end
      ccr <= ccr_nxt;
    end
  end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed self-checking bench for alu_issue_ctrl
module tb_alu_issue_ctrl;
  logic clk = 0, rst = 1;
  logic iss_valid = 0, iss_ready;
  logic [3:0] iss_op = 0;
  logic [1:0] iss_ra = 0, iss_rd = 0;
  logic [7:0] iss_a = 0, iss_b = 0;
  logic [7:0] alu_a, alu_b, alu_out;
  logic [3:0] alu_op;
  logic [1:0] alu_ra;
  logic alu_c, alu_z, alu_n, alu_v;
  logic wb_valid, wb_ready = 1, wb_err;
  logic [7:0] wb_data;
  logic [1:0] wb_rd;
  logic [3:0] ccr;
`ifdef ALU_CCR_LOAD_EN
  logic ccr_ld = 0;
  logic [3:0] ccr_din = 0;
`endif
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  alu_issue_ctrl dut (
    .clk(clk), .rst(rst),
`ifdef ALU_CCR_LOAD_EN
    .ccr_ld(ccr_ld), .ccr_din(ccr_din),
`endif
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_op(iss_op), .iss_ra(iss_ra),
    .iss_a(iss_a), .iss_b(iss_b), .iss_rd(iss_rd),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_ra(alu_ra),
    .alu_out(alu_out), .alu_c(alu_c), .alu_z(alu_z), .alu_n(alu_n), .alu_v(alu_v),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_rd(wb_rd),
    .wb_err(wb_err), .ccr(ccr)
  );
  // ALU stand-in; flags for NOT, CLRC/SETC and illegal ops are deliberately hostile
  logic [8:0] r;
  always_comb begin
    r = {1'b0, alu_a};
    alu_c = 0;
    alu_v = 0;
    alu_z = 0;
    alu_n = 0;
    case (alu_op)
      4'h2: begin r = {1'b0, alu_a} + {1'b0, alu_b}; alu_c = r[8]; alu_v = alu_a[7] == alu_b[7] && r[7] != alu_a[7]; end
      4'h3: begin r = {1'b0, alu_a - alu_b}; alu_c = alu_a < alu_b; alu_v = alu_a[7] != alu_b[7] && r[7] != alu_a[7]; end
      4'h4: r = {1'b0, alu_a & alu_b};
      4'h5: r = {1'b0, alu_a | alu_b};
      4'h8: begin r = alu_ra[0] ? {1'b0, -alu_a} : {1'b0, ~alu_a}; alu_v = 1; end
      default: ;
    endcase
    alu_out = r[7:0];
    alu_z = r[7:0] == 0;
    alu_n = r[7];
    if (alu_op == 4'h6) begin alu_c = ~alu_ra[0]; alu_z = 1; alu_n = 1; alu_v = 1; end
    if (!(alu_op inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h8})) begin
      alu_out = 8'hAA; alu_c = 1; alu_z = 1; alu_n = 1; alu_v = 1;
    end
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  // returns at the EXEC cycle
  task automatic issue(input logic [3:0] op, input logic [1:0] ra, input logic [7:0] a, input logic [7:0] b, input logic [1:0] rd);
    iss_op = op; iss_ra = ra; iss_a = a; iss_b = b; iss_rd = rd; iss_valid = 1;
    tick;
    iss_valid = 0;
  endtask
  initial begin
    tick; tick;
    rst = 0;
    check("rst_ready", iss_ready, 1);
    check("rst_wbv", wb_valid, 0);
    check("rst_ccr", ccr, 0);
    check("rst_alu", {alu_a, alu_b, alu_op, alu_ra}, 0);
    check("rst_wb", {wb_data, wb_rd, wb_err}, 0);
    tick;
    issue(4'h2, 2'b00, 8'h7F, 8'h01, 2'd1);
    check("add_exec_v", wb_valid, 0);
    check("add_exec_rdy", iss_ready, 0);
    check("add_alu_a", alu_a, 8'h7F);
    tick;
    check("add_wbv", wb_valid, 1);
    check("add_data", wb_data, 8'h80);
    check("add_rd", wb_rd, 1);
    check("add_ccr", ccr, 4'b0011);
    tick;
    check("add_idle", iss_ready, 1);
    issue(4'h3, 2'b00, 8'h05, 8'h05, 2'd2);
    tick;
    check("sub_data", wb_data, 8'h00);
    check("sub_ccr", ccr, 4'b0100);
    tick;
    issue(4'h6, 2'b11, 8'h00, 8'h00, 2'd0);
    check("setc_exec_rdy", iss_ready, 0);
    tick;
    check("setc_rdy", iss_ready, 1);
    check("setc_wbv", wb_valid, 0);
    check("setc_ccr", ccr, 4'b1100);
    issue(4'h8, 2'b00, 8'h0F, 8'h00, 2'd3);
    tick;
    check("not1_data", wb_data, 8'hF0);
    check("not1_ccr", ccr, 4'b1010);
    tick;
    issue(4'h6, 2'b10, 8'h00, 8'h00, 2'd0);
    tick;
    check("clrc_wbv", wb_valid, 0);
    check("clrc_ccr", ccr, 4'b0010);
    issue(4'h8, 2'b00, 8'hFF, 8'hFF, 2'd0);
    tick;
    check("not2_ccr", ccr, 4'b0100);
    tick;
    wb_ready = 0;
    issue(4'h4, 2'b00, 8'hF0, 8'h3C, 2'd2);
    tick;
    for (int i = 0; i < 5; i++) begin
      check("stall_wbv", wb_valid, 1);
      check("stall_data", {wb_data, wb_rd}, {8'h30, 2'd2});
      check("stall_rdy", iss_ready, 0);
      iss_op = 4'h2; iss_a = 8'h11; iss_b = 8'h22; iss_rd = 2'd1; iss_valid = (i % 2) == 0;
      tick;
    end
    iss_valid = 0;
    check("stall_ccr", ccr, 4'b0000);
    check("stall_alu_a", alu_a, 8'hF0);
    wb_ready = 1;
    tick;
    check("release_rdy", iss_ready, 1);
    check("release_wbv", wb_valid, 0);
    issue(4'h6, 2'b11, 8'h00, 8'h00, 2'd0);
    tick;
    check("setc2_ccr", ccr, 4'b1000);
    issue(4'hF, 2'b00, 8'h12, 8'h34, 2'd3);
    tick;
    check("ill_wbv", wb_valid, 1);
    check("ill_err", wb_err, 1);
    check("ill_data", wb_data, 8'h00);
    check("ill_rd", wb_rd, 3);
    check("ill_ccr", ccr, 4'b1000);
    tick;
    issue(4'h2, 2'b00, 8'h7F, 8'h01, 2'd1);
    check("legal_after_ill_exec", wb_err, 1);
    rst = 1;
    tick;
    rst = 0;
    check("mid_rst_ready", iss_ready, 1);
    check("mid_rst_wbv", wb_valid, 0);
    check("mid_rst_ccr", ccr, 0);
    check("mid_rst_alu", {alu_a, alu_b, alu_op, alu_ra}, 0);
    check("mid_rst_wb", {wb_data, wb_rd, wb_err}, 0);
`ifdef ALU_CCR_LOAD_EN
    issue(4'h2, 2'b00, 8'h7F, 8'h01, 2'd1);
    ccr_ld = 1; ccr_din = 4'b1010;
    tick;
    ccr_ld = 0;
    check("ld_ccr", ccr, 4'b1010);
    check("ld_data", wb_data, 8'h80);
    tick;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
